// File: rtl/pe_chain_driver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_chain_driver_if: operand stream, PE chain bus and result stream. Rev 1.0
// ---------------------------------------------------------------------------
interface pe_chain_driver_if #(
  parameter int DATA_WIDTH   = 12,
  parameter int OUTPUT_WIDTH = 12,
  parameter int NUM_PE       = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [DATA_WIDTH-1:0]        in_data;
  logic [DATA_WIDTH-1:0]        in_weight;
  logic [OUTPUT_WIDTH-1:0]      in_bias;
  logic [NUM_PE*DATA_WIDTH-1:0] pe_data;
  logic [NUM_PE*DATA_WIDTH-1:0] pe_weight;
  logic [NUM_PE-1:0]            pe_wr_en;
  logic                         pe_start;
  logic [OUTPUT_WIDTH-1:0]      pe_partial_in;
  logic                         chain_done;
  logic [OUTPUT_WIDTH-1:0]      chain_partial;
  logic                         res_valid;
  logic                         res_ready;
  logic [OUTPUT_WIDTH-1:0]      res_data;
  logic                         res_timeout;

  modport slave (
    input  in_valid, in_data, in_weight, in_bias, chain_done, chain_partial, res_ready,
    output in_ready, pe_data, pe_weight, pe_wr_en, pe_start, pe_partial_in,
           res_valid, res_data, res_timeout
  );

  modport master (
    output in_valid, in_data, in_weight, in_bias, chain_done, chain_partial, res_ready,
    input  in_ready, pe_data, pe_weight, pe_wr_en, pe_start, pe_partial_in,
           res_valid, res_data, res_timeout
  );
endinterface
`default_nettype wire

// File: rtl/pe_chain_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_chain_driver: loads, fires and collects one systolic PE MAC row. Rev 1.0
// ---------------------------------------------------------------------------
module pe_chain_driver #(
  parameter int DATA_WIDTH     = 12,
  parameter int OUTPUT_WIDTH   = 12,
  parameter int NUM_PE         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  pe_chain_driver_if.slave    bus_io,
  output logic                busy_o
);
  localparam int BEAT_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(NUM_PE - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ARM   = 3'd2,
    FIRE  = 3'd3,
    WAIT  = 3'd4,
    CLEAR = 3'd5,
    OUT   = 3'd6
  } state_e;

  state_e                       state_q;
  logic [BEAT_W-1:0]            beat_q;
  logic [CNT_W-1:0]             wait_cnt_q;
  logic [NUM_PE*DATA_WIDTH-1:0] data_q;
  logic [NUM_PE*DATA_WIDTH-1:0] weight_q;
  logic [OUTPUT_WIDTH-1:0]      bias_q;
  logic [OUTPUT_WIDTH-1:0]      res_data_q;
  logic                         res_timeout_q;
  logic                         in_ready;
  logic                         chain_armed;
  logic                         accept;

  assign in_ready    = (state_q == IDLE) || (state_q == LOAD);
  assign chain_armed = (state_q == ARM) || (state_q == FIRE) || (state_q == WAIT);
  assign accept      = bus_io.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      wait_cnt_q    <= '0;
      data_q        <= '0;
      weight_q      <= '0;
      bias_q        <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        data_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH]   <= bus_io.in_data;
        weight_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] <= bus_io.in_weight;
        if (beat_q == '0) begin
          bias_q <= bus_io.in_bias;
        end
      end

      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            if (beat_q == LAST_BEAT) begin
              beat_q  <= '0;
              state_q <= ARM;
            end else begin
              beat_q  <= beat_q + BEAT_W'(1);
              state_q <= LOAD;
            end
          end
        end
        ARM:  state_q <= FIRE;
        FIRE: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        // A result arriving on the expiry cycle takes priority over the timeout.
        WAIT: begin
          if (bus_io.chain_done) begin
            res_data_q    <= bus_io.chain_partial;
            res_timeout_q <= 1'b0;
            state_q       <= CLEAR;
          end else if (wait_cnt_q == TIMEOUT_CNT) begin
            res_data_q    <= '0;
            res_timeout_q <= 1'b1;
            state_q       <= CLEAR;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        CLEAR: state_q <= OUT;
        OUT: begin
          if (bus_io.res_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.in_ready      = in_ready;
  assign bus_io.pe_data       = data_q;
  assign bus_io.pe_weight     = weight_q;
  assign bus_io.pe_partial_in = bias_q;
  assign bus_io.pe_wr_en      = {NUM_PE{chain_armed}};
  assign bus_io.pe_start      = (state_q == FIRE);
  assign bus_io.res_valid     = (state_q == OUT);
  assign bus_io.res_data      = res_data_q;
  assign bus_io.res_timeout   = res_timeout_q;
  assign busy_o               = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_pe_chain_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pe_chain_driver: directed bench with a behavioural PE row and scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
module tb_pe_chain_driver;
  localparam int DW = 12;
  localparam int OW = 12;
  localparam int N  = 4;
  localparam int T  = 64;

  typedef struct packed {
    logic          to;
    logic [OW-1:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic disconnect = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  pe_chain_driver_if #(.DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .NUM_PE(N)) bus ();

  pe_chain_driver #(
    .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .NUM_PE(N), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_io(bus), .busy_o(busy)
  );

  // Behavioural PE row: each PE latches done once per job, cleared by wr_en=0.
  logic [N-1:0]  done_q;
  logic [OW-1:0] part_q [N];

  function automatic logic [OW-1:0] mac(input logic [OW-1:0] p, input logic [DW-1:0] d,
                                        input logic [DW-1:0] w);
    logic [2*DW-1:0] prod;
    prod = d * w;
    return p + prod[OW-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
      for (int k = 0; k < N; k++) part_q[k] <= '0;
    end else begin
      if (!bus.pe_wr_en[0]) done_q[0] <= 1'b0;
      else if (bus.pe_start && !done_q[0]) begin
        done_q[0] <= 1'b1;
        part_q[0] <= mac(bus.pe_partial_in, bus.pe_data[0 +: DW], bus.pe_weight[0 +: DW]);
      end
      for (int k = 1; k < N; k++) begin
        if (!bus.pe_wr_en[k]) done_q[k] <= 1'b0;
        else if (done_q[k-1] && !done_q[k]) begin
          done_q[k] <= 1'b1;
          part_q[k] <= mac(part_q[k-1], bus.pe_data[k*DW +: DW], bus.pe_weight[k*DW +: DW]);
        end
      end
    end
  end

  assign bus.chain_done    = disconnect ? 1'b0 : done_q[N-1];
  assign bus.chain_partial = part_q[N-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ends at the falling edge just after the last beat is accepted.
  task automatic send_job(input logic [N*DW-1:0] d, input logic [N*DW-1:0] w,
                          input logic [OW-1:0] b, input logic exp_to,
                          input logic [OW-1:0] exp_data);
    int n;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = d[k*DW +: DW];
      bus.in_weight = w[k*DW +: DW];
      bus.in_bias   = b;
      n = 0;
      while (!bus.in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!bus.in_ready) check("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp_q.push_back('{to: exp_to, data: exp_data});
  endtask

  task automatic get_result(input string tag, input int budget, input logic keep_ready);
    int   n;
    res_t e;
    n = 0;
    while (!bus.res_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {63'd0, bus.res_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, {52'd0, bus.res_data}, {52'd0, e.data});
      check({tag, "_timeout"}, {63'd0, bus.res_timeout}, {63'd0, e.to});
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = keep_ready;
  endtask

  localparam logic [N*DW-1:0] D_BASIC = {12'd4, 12'd3, 12'd2, 12'd1};
  localparam logic [N*DW-1:0] W_TWO   = {4{12'd2}};
  localparam logic [N*DW-1:0] V_63    = {4{12'd63}};
  localparam logic [N*DW-1:0] V_ONE   = {4{12'd1}};

  initial begin
    int starts;
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_weight = '0;
    bus.in_bias   = '0;
    bus.res_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
    check("rst_wr_en", {60'd0, bus.pe_wr_en}, 64'd0);
    check("rst_start", {63'd0, bus.pe_start}, 64'd0);
    check("rst_res_data", {52'd0, bus.res_data}, 64'd0);
    rst_n = 1'b1;

    // Basic job with cycle-accurate timing relative to the last accepted beat
    send_job(D_BASIC, W_TWO, 12'd5, 1'b0, 12'd25);
    starts = 0;
    for (int i = 0; i < 7; i++) begin
      if (bus.pe_start) starts++;
      if (i == 0) begin
        check("arm_wr_en", {60'd0, bus.pe_wr_en}, 64'hF);
        check("arm_pe_data", {16'd0, bus.pe_data}, {16'd0, D_BASIC});
        check("arm_pe_weight", {16'd0, bus.pe_weight}, {16'd0, W_TWO});
        check("arm_partial_in", {52'd0, bus.pe_partial_in}, 64'd5);
      end
      if (i == 1) check("fire_start", {63'd0, bus.pe_start}, 64'd1);
      if (i == 5) check("wait_wr_en", {60'd0, bus.pe_wr_en}, 64'hF);
      if (i == 6) begin
        check("clear_wr_en", {60'd0, bus.pe_wr_en}, 64'd0);
        check("clear_res_valid", {63'd0, bus.res_valid}, 64'd0);
      end
      @(negedge clk);
    end
    check("start_cycles", starts, 64'd1);
    check("basic_latency_valid", {63'd0, bus.res_valid}, 64'd1);
    get_result("basic", 0, 1'b0);
    check("post_hs_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Wrap-around modulo 2^12
    send_job(V_63, V_63, 12'd0, 1'b0, 12'd3588);
    get_result("wrap", 20, 1'b0);

    // Back-to-back with res_ready tied high
    bus.res_ready = 1'b1;
    send_job(D_BASIC, W_TWO, 12'd5, 1'b0, 12'd25);
    get_result("b2b_first", 20, 1'b1);
    send_job(V_ONE, V_ONE, 12'd0, 1'b0, 12'd4);
    get_result("b2b_second", 20, 1'b0);

    // Timeout with the chain disconnected
    disconnect = 1'b1;
    send_job(D_BASIC, W_TWO, 12'd5, 1'b1, 12'd0);
    n = 0;
    while (!bus.res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, T + 4);
    check("timeout_busy", {63'd0, busy}, 64'd1);
    get_result("timeout", 0, 1'b0);
    disconnect = 1'b0;

    // Backpressure: result held, operand beats ignored
    send_job(D_BASIC, W_TWO, 12'd5, 1'b0, 12'd25);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = DW'($urandom);
      bus.in_weight = DW'($urandom);
      bus.in_bias   = OW'($urandom);
      @(negedge clk);
      check("bp_res_valid", {63'd0, bus.res_valid}, 64'd1);
      check("bp_res_data", {52'd0, bus.res_data}, 64'd25);
      check("bp_busy", {63'd0, busy}, 64'd1);
      check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.in_valid = 1'b0;
    check("bp_pe_data", {16'd0, bus.pe_data}, {16'd0, D_BASIC});
    get_result("bp", 0, 1'b0);
    check("bp_release_busy", {63'd0, busy}, 64'd0);
    check("bp_release_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Asynchronous reset in the middle of WAIT
    send_job(D_BASIC, W_TWO, 12'd5, 1'b0, 12'd25);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_wr_en", {60'd0, bus.pe_wr_en}, 64'd0);
    check("mrst_start", {63'd0, bus.pe_start}, 64'd0);
    check("mrst_res_valid", {63'd0, bus.res_valid}, 64'd0);
    check("mrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_pe_data", {16'd0, bus.pe_data}, 64'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    send_job(V_ONE, V_ONE, 12'd0, 1'b0, 12'd4);
    get_result("after_rst", 20, 1'b0);

    check("sb_drained", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
